// File: rtl/game_display.sv
// game_display: display back end for the reaction game.
// Converts the clamped 'number' to BCD with a sequential double-dabble engine,
// scans four multiplexed seven-segment digits, and renders the per-phase
// presentation (menu, blinking target, running count, result).
module game_display #(
  parameter int REFRESH_TICKS = 100000,
  parameter int BLINK_TICKS   = 25000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  select,
  input  logic [1:0]  mode,
  input  logic [13:0] number,
  output logic [6:0]  seg,
  output logic        dp,
  output logic [3:0]  an
);

  localparam int RW = (REFRESH_TICKS > 1) ? $clog2(REFRESH_TICKS) : 1;
  localparam int BW = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;
  localparam logic [RW-1:0] REFRESH_LAST = RW'(REFRESH_TICKS - 1);
  localparam logic [BW-1:0] BLINK_LAST   = BW'(BLINK_TICKS - 1);

  localparam logic [6:0] SEG_DASH  = 7'b0111111;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SHIFT, S_DONE} state_t;

  // Active-low segment pattern for one decimal digit; anything else is blank.
  function automatic logic [6:0] seg_code(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

  // Double-dabble correction: add 3 to every BCD nibble that is 5 or more.
  function automatic logic [15:0] add3(input logic [15:0] v);
    logic [15:0] r;
    r = v;
    for (int i = 0; i < 4; i++) begin
      if (v[4*i +: 4] >= 4'd5) r[4*i +: 4] = v[4*i +: 4] + 4'd3;
      else                      r[4*i +: 4] = v[4*i +: 4];
    end
    return r;
  endfunction

  state_t        r_state, w_state_nxt;
  logic [13:0]   r_snap, w_snap_nxt;
  logic [15:0]   r_scratch, w_scratch_nxt;
  logic [3:0]    r_iter, w_iter_nxt;
  logic [15:0]   r_bcd_disp, w_bcd_disp_nxt;
  logic [13:0]   w_clamped;

  logic [RW-1:0] r_refresh_cnt;
  logic [1:0]    r_digit_idx;

  logic [1:0]    r_sel_prev;
  logic [BW-1:0] r_blink_cnt, w_blink_cnt_nxt;
  logic          r_blink_on, w_blink_on_nxt;

  logic [15:0]   w_upper;
  logic [3:0]    w_nib;
  logic [6:0]    w_seg;
  logic          w_dp;
  logic [3:0]    w_an;

  assign w_clamped = (number > 14'd9999) ? 14'd9999 : number;

  // Converter state and datapath registers; reset throws away any partial scratch.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_snap     <= 14'd0;
      r_scratch  <= 16'd0;
      r_iter     <= 4'd0;
      r_bcd_disp <= 16'd0;
    end else begin
      r_state    <= w_state_nxt;
      r_snap     <= w_snap_nxt;
      r_scratch  <= w_scratch_nxt;
      r_iter     <= w_iter_nxt;
      r_bcd_disp <= w_bcd_disp_nxt;
    end
  end

  // Converter next state: LOAD, 14 correct-and-shift steps, then publish in DONE.
  always_comb begin
    w_state_nxt    = r_state;
    w_snap_nxt     = r_snap;
    w_scratch_nxt  = r_scratch;
    w_iter_nxt     = r_iter;
    w_bcd_disp_nxt = r_bcd_disp;
    case (r_state)
      S_IDLE: begin
        w_state_nxt = S_LOAD;
      end
      S_LOAD: begin
        w_snap_nxt    = w_clamped;
        w_scratch_nxt = 16'd0;
        w_iter_nxt    = 4'd0;
        w_state_nxt   = S_SHIFT;
      end
      S_SHIFT: begin
        w_scratch_nxt = (add3(r_scratch) << 1) | {15'd0, r_snap[13]};
        w_snap_nxt    = {r_snap[12:0], 1'b0};
        w_iter_nxt    = r_iter + 4'd1;
        if (r_iter == 4'd13) w_state_nxt = S_DONE;
        else                 w_state_nxt = S_SHIFT;
      end
      S_DONE: begin
        w_bcd_disp_nxt = r_scratch;
        w_state_nxt    = S_LOAD;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Digit scan: advance to the next digit slot every REFRESH_TICKS clocks.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_refresh_cnt <= '0;
      r_digit_idx   <= 2'd0;
    end else if (r_refresh_cnt == REFRESH_LAST) begin
      r_refresh_cnt <= '0;
      r_digit_idx   <= r_digit_idx + 2'd1;
    end else begin
      r_refresh_cnt <= r_refresh_cnt + 1'b1;
    end
  end

  // Blink timer next values; a phase change restarts the blink in the lit half.
  always_comb begin
    w_blink_cnt_nxt = r_blink_cnt;
    w_blink_on_nxt  = r_blink_on;
    if (select != r_sel_prev) begin
      w_blink_cnt_nxt = '0;
      w_blink_on_nxt  = 1'b1;
    end else if (r_blink_cnt == BLINK_LAST) begin
      w_blink_cnt_nxt = '0;
      w_blink_on_nxt  = ~r_blink_on;
    end else begin
      w_blink_cnt_nxt = r_blink_cnt + 1'b1;
    end
  end

  // Blink timer and registered copy of the phase used for change detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sel_prev  <= 2'd0;
      r_blink_cnt <= '0;
      r_blink_on  <= 1'b1;
    end else begin
      r_sel_prev  <= select;
      r_blink_cnt <= w_blink_cnt_nxt;
      r_blink_on  <= w_blink_on_nxt;
    end
  end

  // Glyph selection for the current digit slot and phase.
  always_comb begin
    w_upper = r_bcd_disp >> {r_digit_idx, 2'b00};
    w_nib   = w_upper[3:0];
    w_seg   = SEG_BLANK;
    w_dp    = 1'b1;
    w_an    = ~(4'b0001 << r_digit_idx);
    case (select)
      2'd0: begin
        if (r_digit_idx != 2'd0) w_seg = SEG_DASH;
        else if (mode == 2'd3)   w_seg = SEG_DASH;
        else                     w_seg = seg_code({2'b00, mode});
      end
      2'd1, 2'd2, 2'd3: begin
        // Leading-zero blanking: this digit and everything above it are zero.
        if ((r_digit_idx != 2'd0) && (w_upper == 16'd0)) w_seg = SEG_BLANK;
        else                                            w_seg = seg_code(w_nib);
        if (select == 2'd2) w_dp = 1'b0;
        else                w_dp = 1'b1;
        if ((select == 2'd3) && !w_blink_on_nxt) w_an = 4'b1111;
        else                                    w_an = ~(4'b0001 << r_digit_idx);
      end
      default: begin
        w_seg = SEG_BLANK;
      end
    endcase
  end

  // Registered pin drivers; everything dark while in reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seg <= SEG_BLANK;
      dp  <= 1'b1;
      an  <= 4'b1111;
    end else begin
      seg <= w_seg;
      dp  <= w_dp;
      an  <= w_an;
    end
  end

endmodule

// File: tb/tb_game_display.sv
// tb_game_display: randomized scoreboard bench for game_display.
// A reference model predicts every clock's pin state from the phase rules and
// decimal arithmetic; a monitor compares each prediction against the pins.
module tb_game_display;

  localparam int R = 4;
  localparam int B = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  select;
  logic [1:0]  mode;
  logic [13:0] number;
  logic [6:0]  seg;
  logic        dp;
  logic [3:0]  an;

  game_display #(.REFRESH_TICKS(R), .BLINK_TICKS(B)) dut (
    .clk(clk), .rst(rst), .select(select), .mode(mode), .number(number),
    .seg(seg), .dp(dp), .an(an)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       full;  // seg/dp meaningful (not in a blink-dark slot)
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  // model state
  int         m_n, m_disp, m_snap, m_entry;
  logic [1:0] m_sel_prev;

  function automatic logic [6:0] glyph(input int d);
    case (d)
      0: return 7'b1000000;
      1: return 7'b1111001;
      2: return 7'b0100100;
      3: return 7'b0110000;
      4: return 7'b0011001;
      5: return 7'b0010010;
      6: return 7'b0000010;
      7: return 7'b1111000;
      8: return 7'b0000000;
      9: return 7'b0010000;
      default: return 7'b1111111;
    endcase
  endfunction

  function automatic int pow10(input int i);
    int p;
    p = 1;
    for (int j = 0; j < i; j++) p = p * 10;
    return p;
  endfunction

  task automatic chk(input string name, input logic [6:0] act, input logic [6:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %b, expected %b (t=%0t)", name, act, req, $time);
  endtask

  // Reference model: one prediction per clock edge.
  always @(posedge clk) begin
    exp_t e;
    int   idx, k;
    bit   blink_on;
    if (rst) begin
      m_n = 0; m_disp = 0; m_snap = 0; m_entry = 0; m_sel_prev = 2'd0;
      e.an = 4'b1111; e.seg = 7'b1111111; e.dp = 1'b1; e.full = 1'b1;
    end else begin
      m_n++;
      if (select != m_sel_prev) m_entry = m_n;
      m_sel_prev = select;
      k        = m_n - m_entry;
      blink_on = ((k / B) % 2) == 0;
      idx      = ((m_n - 1) / R) % 4;
      e.an     = ~(4'b0001 << idx);
      e.full   = 1'b1;
      if (select == 2'd0) begin
        e.dp  = 1'b1;
        if (idx != 0)         e.seg = 7'b0111111;
        else if (mode == 2'd3) e.seg = 7'b0111111;
        else                  e.seg = glyph(int'(mode));
      end else begin
        e.dp  = (select == 2'd2) ? 1'b0 : 1'b1;
        if (idx == 0 || m_disp >= pow10(idx)) e.seg = glyph((m_disp / pow10(idx)) % 10);
        else                                  e.seg = 7'b1111111;
        if (select == 2'd3 && !blink_on) begin
          e.an   = 4'b1111;
          e.full = 1'b0;
        end
      end
      // conversion timeline: capture every 16 clocks from edge 2, publish 15 later
      if (m_n >= 17 && ((m_n - 1) % 16) == 0) m_disp = m_snap;
      if (m_n >= 2 && ((m_n - 2) % 16) == 0) m_snap = (int'(number) > 9999) ? 9999 : int'(number);
    end
    exp_q.push_back(e);
  end

  // Monitor: compare pins against the oldest prediction, away from the active edge.
  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("an", {3'b000, an}, {3'b000, e.an});
      if (e.full) begin
        chk("seg", seg, e.seg);
        chk("dp", {6'd0, dp}, {6'd0, e.dp});
      end
    end
  end

  task automatic run(input logic [1:0] s, input logic [1:0] m, input logic [13:0] num, input int cycles);
    select = s;
    mode   = m;
    number = num;
    repeat (cycles) @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; select = 2'd0; mode = 2'd0; number = 14'd0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    run(2'd1, 2'd0, 14'd0,    40);
    run(2'd0, 2'd2, 14'd0,    20);
    run(2'd0, 2'd3, 14'd0,    20);
    run(2'd1, 2'd0, 14'd1234, 50);
    // asynchronous reset in the middle of a scan slot
    #2 rst = 1'b1;
    #1;
    chk("rst_an",  {3'b000, an}, 7'b0001111);
    chk("rst_seg", seg, 7'b1111111);
    chk("rst_dp",  {6'd0, dp}, 7'd1);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    run(2'd1, 2'd0, 14'd1234,  50);
    run(2'd1, 2'd0, 14'd9999,  50);
    run(2'd1, 2'd0, 14'd12000, 50);
    run(2'd1, 2'd0, 14'd7,     50);
    run(2'd1, 2'd0, 14'd0,     50);
    run(2'd2, 2'd0, 14'd500,   50);
    run(2'd3, 2'd0, 14'd42,    70);
    run(2'd1, 2'd0, 14'd42,    10);
    run(2'd3, 2'd0, 14'd42,    20);   // now in the dark half
    run(2'd1, 2'd0, 14'd42,    10);   // must light up on the next clock
    run(2'd1, 2'd0, 14'd1999,  40);
    run(2'd1, 2'd0, 14'd1999,  7);    // land mid-conversion
    run(2'd1, 2'd0, 14'd2000,  40);
    for (int i = 0; i < 40; i++) begin
      logic [13:0] num;
      if ($urandom_range(0, 3) == 0) num = 14'($urandom_range(0, 20));
      else                           num = 14'($urandom_range(0, 16383));
      run(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), num, $urandom_range(1, 60));
    end
    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/game_display.md
# game_display

Display back end for the reaction game: consumes the game controller's `select`, `mode` and `number` outputs and drives the 4-digit multiplexed seven-segment display. It converts `number` to BCD with a sequential double-dabble engine and scans the four digits at a fixed refresh rate. It also renders a per-phase presentation: mode menu, blinking target, running count and result. It sits between the game controller and the board pins.

## Interface
- `REFRESH_TICKS`, 100000: clocks per digit slot (1 kHz per digit at 100 MHz).
- `BLINK_TICKS`, 25000000: clocks per blink half-period.
- `clk` input 1: system clock.
- `rst` input 1: reset, asynchronous, active-high.
- `select` input 2: game phase. 0 = menu, 3 = target show, 1 = running, 2 = result.
- `mode` input 2: difficulty, 0..2.
- `number` input 14: value to display, unsigned.
- `seg` output 7: cathodes {g,f,e,d,c,b,a}, active-low.
- `dp` output 1: decimal point, active-low.
- `an` output 4: anodes, active-low one-hot; `an[0]` is the rightmost digit.

## Operation
- **Clamp:** the converter snapshots `min(number, 9999)`.
- **BCD FSM:** IDLE → LOAD → SHIFT (14 iterations) → DONE → LOAD …, running continuously.
  - LOAD: captures the clamped snapshot and clears the 16-bit BCD scratch.
  - SHIFT: each iteration adds 3 to any nibble ≥5, then shifts left one bit, taking the snapshot MSB.
  - DONE: copies the scratch into `bcd_disp[15:0]` atomically. Partial results are never displayed.
- **Scan:**
  - `refresh_cnt` counts 0..REFRESH_TICKS-1.
  - At terminal count, `digit_idx` (2 bits) increments and wraps 3 → 0.
- **Glyph per phase**, for the digit at `digit_idx`:
  - `select`=0: digits 3..1 show dash. Digit 0 shows `mode` (0, 1 or 2); `mode`=3 shows dash. All dp off.
  - `select`=1: `bcd_disp` with leading-zero blanking. Blanking never applies to digit 0. dp off.
  - `select`=2: same as 1, but dp on for every digit.
  - `select`=3: same as 1, blinking.
- **Blink:**
  - `blink_cnt` counts 0..BLINK_TICKS-1 and toggles `blink_on` at terminal count.
  - Any change of `select` (compared against a registered copy) clears `blink_cnt` and sets `blink_on`=1.
  - When `select`=3 and `blink_on`=0, output `an`=1111.
- **Segment codes** (active-low):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
  - dash=0111111, blank=1111111

## Timing
- **Reset (async):**
  - Outputs: `an`=1111, `seg`=1111111, `dp`=1.
  - Internal state: `digit_idx`=0, `refresh_cnt`=0, `blink_cnt`=0, `blink_on`=1, `bcd_disp`=0, FSM=IDLE.
  - IDLE moves to LOAD on the first clock after reset release.
- **Output registers:** `seg`, `an`, `dp` are registered. They reflect `digit_idx` and the phase inputs sampled on the same edge, so there is 1 cycle of latency.
- **Conversion:** 16 clocks per cycle (LOAD + 14 SHIFT + DONE). A `number` change is visible in `bcd_disp` at most 32 clocks later.
- **Mid-conversion input changes:** a change in `number` is ignored until the next LOAD. A change in `select` does not restart conversion.
- **`select` change:** takes effect on outputs the next clock; no wait for the slot boundary.
- **Reset mid-conversion:** discards the scratch; `bcd_disp`=0.
- **Blanking:** evaluated on `bcd_disp`. Value 0 shows only digit 0 = "0".

## Test plan
Parameters for all scenarios: REFRESH_TICKS=4, BLINK_TICKS=16.

- **Reset:** assert `rst` mid-scan → `an`=1111, `seg`=1111111, `dp`=1 immediately. After release, the first lit slot is `an`=1110.
- **Menu:** `select`=0, `mode`=2 → over one scan, digit 0 `seg`=0100100 and digits 1..3 = 0111111. `mode`=3 → digit 0 = 0111111.
- **Conversion:** `select`=1.
  - `number`=1234 → within 32 clocks digits 3..0 = 1,2,3,4 codes.
  - `number`=9999 → 9999.
  - `number`=12000 → clamps to 9999.
  - `number`=7 → digits 3..1 blank, digit 0 = 1111000.
  - `number`=0 → only digit 0 lit = 1000000.
- **Result:** `select`=2, `number`=500 → digits show " 500" and `dp`=0 on every slot.
- **Blink:** `select`=3, `number`=42 → `an`=1111 for clocks 16..31 after entry, digits lit otherwise. Switching to `select`=1 mid-off-phase → digits lit next clock.
- **Atomicity:** change `number` from 1999 to 2000 during SHIFT → displayed value is only ever 1999 or 2000, never a mix.
